// File: rtl/at45_prog_seq.sv
//-----------------------------------------------------------------------------
// at45_prog_seq
//
// Upstream command sequencer for the AT45DB321 SPI controller (upr_at45db321).
// Programs page_count consecutive 528-byte pages taken from the byte FIFO,
// optionally preceded by a chip erase. Each page is written as:
//   84h  Buffer1 Write            (completes on bufer_full)
//   83h  Buffer1->Page with erase (completes on wr)
//   D7h  Status Register poll     (completes on wr, repeated until RDY)
//
// Optional feature macro: AT45_TIMEOUT_EN
//   defined     : the number of D7h polls per wait is bounded by TIMEOUT_POLLS.
//                 Needing one more poll ends the sequence with error=1 and no done.
//   not defined : polling is unbounded, error is tied low.
//
// Ports
//   clk         system clock, shared with the controller
//   rst         synchronous reset, active high
//   start       1-clk pulse, accepted only while idle
//   erase_all   issue chip erase (C7h) before programming
//   page_start  first page address (0..8191)
//   page_count  number of pages to program (0 = erase only / immediate done)
//   fifo_cnt    bytes currently held in the data FIFO
//   fifo_empty  data FIFO empty
//   wr          controller strobe: 83h/D7h finished, data_out valid
//   data_out    controller read word, RDY = data_out[23]
//   bufer_full  controller strobe: last byte of 84h shifted out
//   command     opcode to controller, held from en until completion
//   en          1-clk start pulse to controller
//   adr_data    {1'b0, page, 10'd0}
//   pause       stalls the controller byte stream while the FIFO is empty
//   busy        sequence in progress
//   done        1-clk pulse on successful completion
//   error       sticky poll-timeout flag, cleared by the next accepted start
//   page_cur    page currently being programmed
//-----------------------------------------------------------------------------
module at45_prog_seq #(
   parameter int PAGE_BYTES    = 528,
   parameter int GAP_CYC       = 40,
   parameter int ERASE_CYC     = 1000,
   parameter int POLL_CYC      = 2000,
   parameter int TIMEOUT_POLLS = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        erase_all,
   input  logic [12:0] page_start,
   input  logic [12:0] page_count,
   input  logic [10:0] fifo_cnt,
   input  logic        fifo_empty,
   input  logic        wr,
   input  logic [31:0] data_out,
   input  logic        bufer_full,
   output logic [7:0]  command,
   output logic        en,
   output logic [23:0] adr_data,
   output logic        pause,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [12:0] page_cur
);

   localparam logic [7:0] OP_ERASE = 8'hC7;
   localparam logic [7:0] OP_BUF   = 8'h84;
   localparam logic [7:0] OP_PROG  = 8'h83;
   localparam logic [7:0] OP_POLL  = 8'hD7;

   // One shared delay counter serves every timed state, so it is sized for
   // the longest of the three waits.
   localparam int CNT_MAX_A = (GAP_CYC > ERASE_CYC) ? GAP_CYC : ERASE_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > POLL_CYC) ? CNT_MAX_A : POLL_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYC - 1);
   localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYC - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ERASE_CMD,
      S_ERASE_WT,
      S_WAIT_DATA,
      S_BUF_CMD,
      S_BUF_WT,
      S_PROG_CMD,
      S_PROG_WT,
      S_POLL_CMD,
      S_POLL_WT,
      S_POLL_GAP,
      S_GAP,
      S_ERASED,
      S_PROGRAMMED,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state_q,     state_d;
   state_t           ret_q,       ret_d;        // where GAP goes when it expires
   state_t           poll_ret_q,  poll_ret_d;   // where a successful poll sequence goes
   logic [7:0]       command_q,   command_d;
   logic [12:0]      page_q,      page_d;
   logic [12:0]      remaining_q, remaining_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

`ifdef AT45_TIMEOUT_EN
   localparam int POLL_W = $clog2(TIMEOUT_POLLS + 1);
   localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(TIMEOUT_POLLS);

   logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
   logic              error_q,    error_d;
`endif

   //--------------------------------------------------------------------------
   // Next-state and datapath logic
   //--------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d     = state_q;
      ret_d       = ret_q;
      poll_ret_d  = poll_ret_q;
      command_d   = command_q;
      page_d      = page_q;
      remaining_d = remaining_q;
      cnt_d       = cnt_q;
`ifdef AT45_TIMEOUT_EN
      poll_cnt_d  = poll_cnt_q;
      error_d     = error_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               page_d      = page_start;
               remaining_d = page_count;
`ifdef AT45_TIMEOUT_EN
               error_d     = 1'b0;
`endif
               if (erase_all)
                  state_d = S_ERASE_CMD;
               else if (page_count == '0)
                  state_d = S_DONE;
               else
                  state_d = S_WAIT_DATA;
            end
         end

         S_ERASE_CMD: state_d = S_ERASE_WT;

         // Chip erase gives no completion strobe: wait a fixed time, then poll.
         S_ERASE_WT: begin
            if (cnt_q == ERASE_LAST) begin
               state_d    = S_POLL_CMD;
               poll_ret_d = S_ERASED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_WAIT_DATA: begin
            if (fifo_cnt >= 11'(PAGE_BYTES))
               state_d = S_BUF_CMD;
         end

         S_BUF_CMD: state_d = S_BUF_WT;

         S_BUF_WT: begin
            if (bufer_full) begin
               state_d = S_GAP;
               ret_d   = S_PROG_CMD;
            end
         end

         S_PROG_CMD: state_d = S_PROG_WT;

         S_PROG_WT: begin
            if (wr) begin
               state_d    = S_GAP;
               ret_d      = S_POLL_CMD;
               poll_ret_d = S_PROGRAMMED;
            end
         end

         S_POLL_CMD: state_d = S_POLL_WT;

         // The status byte arrives together with wr, so RDY is judged on the
         // strobe cycle itself.
         S_POLL_WT: begin
            if (wr) begin
               if (data_out[23]) begin
                  state_d = S_GAP;
                  ret_d   = poll_ret_q;
               end else begin
                  state_d = S_POLL_GAP;
               end
            end
         end

         S_POLL_GAP: begin
            if (cnt_q == POLL_LAST)
               state_d = S_POLL_CMD;
            else
               cnt_d = cnt_q + CNT_W'(1);
         end

         S_GAP: begin
            if (cnt_q == GAP_LAST)
               state_d = ret_q;
            else
               cnt_d = cnt_q + CNT_W'(1);
         end

         S_ERASED: begin
            if (remaining_q == '0)
               state_d = S_DONE;
            else
               state_d = S_WAIT_DATA;
         end

         S_PROGRAMMED: begin
            remaining_d = remaining_q - 13'd1;
            if (remaining_q == 13'd1) begin
               state_d = S_DONE;
            end else begin
               page_d  = page_q + 13'd1;   // 13-bit wrap 8191 -> 0
               state_d = S_WAIT_DATA;
            end
         end

         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef AT45_TIMEOUT_EN
      // The counter is cleared in the command state that precedes each wait,
      // so it always starts at zero when the first poll of a wait is issued.
      if (state_q == S_ERASE_CMD || state_q == S_PROG_CMD)
         poll_cnt_d = '0;

      // Every entry into POLL_CMD is one more D7h issue; the issue that would
      // exceed the limit becomes the error exit instead.
      if (state_d == S_POLL_CMD && state_q != S_POLL_CMD) begin
         if (poll_cnt_q == POLL_LIMIT) begin
            state_d = S_ERR;
            error_d = 1'b1;
         end else begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
         end
      end
`endif

      // Opcode is loaded on the edge that enters a command state, so it is
      // already valid during the en cycle and held until the next command.
      unique case (state_d)
         S_ERASE_CMD: command_d = OP_ERASE;
         S_BUF_CMD:   command_d = OP_BUF;
         S_PROG_CMD:  command_d = OP_PROG;
         S_POLL_CMD:  command_d = OP_POLL;
         default:     ;
      endcase

      // Each timed state starts counting from zero on entry.
      if (state_d != state_q)
         cnt_d = '0;
   end

   //--------------------------------------------------------------------------
   // State register
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q     <= S_IDLE;
         ret_q       <= S_IDLE;
         poll_ret_q  <= S_IDLE;
         command_q   <= 8'h00;
         page_q      <= '0;
         remaining_q <= '0;
         cnt_q       <= '0;
`ifdef AT45_TIMEOUT_EN
         poll_cnt_q  <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         poll_ret_q  <= poll_ret_d;
         command_q   <= command_d;
         page_q      <= page_d;
         remaining_q <= remaining_d;
         cnt_q       <= cnt_d;
`ifdef AT45_TIMEOUT_EN
         poll_cnt_q  <= poll_cnt_d;
         error_q     <= error_d;
`endif
      end
   end

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   // Command states last exactly one clock, which makes en a single pulse.
   assign en = (state_q == S_ERASE_CMD) || (state_q == S_BUF_CMD) ||
               (state_q == S_PROG_CMD)  || (state_q == S_POLL_CMD);

   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
   assign done     = (state_q == S_DONE);
   assign pause    = (state_q == S_BUF_WT) && fifo_empty;
   assign command  = command_q;
   assign page_cur = page_q;
   assign adr_data = {1'b0, page_q, 10'd0};

   // Only the RDY bit of the status word is of interest.
`ifdef AT45_TIMEOUT_EN
   assign error = error_q;

   logic unused_bits;
   assign unused_bits = ^{data_out[31:24], data_out[22:0]};
`else
   assign error = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{data_out[31:24], data_out[22:0], 1'(TIMEOUT_POLLS)};
`endif

endmodule

// File: tb/tb_at45_prog_seq.sv
//-----------------------------------------------------------------------------
// tb_at45_prog_seq
//
// Bench for at45_prog_seq. A small controller/flash model answers en pulses
// with bufer_full / wr strobes and reports RDY after a chosen number of polls.
// A job-level reference model turns each accepted start into the list of
// commands, minimum idle gaps and terminal event it must produce; a monitor
// compares every en / done / error edge against that list.
//-----------------------------------------------------------------------------
module tb_at45_prog_seq;

   localparam int GAP_CYC    = 40;
   localparam int ERASE_CYC  = 1000;
   localparam int POLL_CYC   = 2000;
   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        erase_all;
   logic [12:0] page_start;
   logic [12:0] page_count;
   logic [10:0] fifo_cnt;
   logic        fifo_empty;
   logic        wr;
   logic [31:0] data_out;
   logic        bufer_full;
   logic [7:0]  command;
   logic        en;
   logic [23:0] adr_data;
   logic        pause;
   logic        busy;
   logic        done;
   logic        error;
   logic [12:0] page_cur;

   at45_prog_seq #(
      .PAGE_BYTES    (528),
      .GAP_CYC       (GAP_CYC),
      .ERASE_CYC     (ERASE_CYC),
      .POLL_CYC      (POLL_CYC),
      .TIMEOUT_POLLS (TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .erase_all  (erase_all),
      .page_start (page_start),
      .page_count (page_count),
      .fifo_cnt   (fifo_cnt),
      .fifo_empty (fifo_empty),
      .wr         (wr),
      .data_out   (data_out),
      .bufer_full (bufer_full),
      .command    (command),
      .en         (en),
      .adr_data   (adr_data),
      .pause      (pause),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .page_cur   (page_cur)
   );

   always #5 clk = ~clk;

   //--------------------------------------------------------------------------
   // Bookkeeping
   //--------------------------------------------------------------------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int info);
      total++;
      bad++;
      $display("FAIL %s: got %0d", name, info);
   endtask

   task automatic check_range(input string name, input int v, input int lo, input int hi);
      total++;
      if (v < lo || v > hi) begin
         bad++;
         $display("FAIL %s: got %0d want %0d..%0d", name, v, lo, hi);
      end
   endtask

   //--------------------------------------------------------------------------
   // Reference model: expected events per job
   //--------------------------------------------------------------------------
   typedef enum int {EV_EN, EV_DONE, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [7:0]  cmd;
      logic [23:0] adr;
      bit          chk_adr;
      int          min_gap;   // 0 = spacing not checked
   } ev_t;

   ev_t exp_q[$];

   task automatic push_ev(input ev_kind_t k, input logic [7:0] c, input logic [23:0] a,
                          input bit ca, input int g);
      ev_t e;
      e.kind    = k;
      e.cmd     = c;
      e.adr     = a;
      e.chk_adr = ca;
      e.min_gap = g;
      exp_q.push_back(e);
   endtask

   task automatic model_polls(input int n, input int first_gap);
      for (int i = 0; i < n; i++)
         push_ev(EV_EN, 8'hD7, 24'h0, 1'b0, (i == 0) ? first_gap : POLL_CYC);
   endtask

   task automatic model_job(input int ps, input int pc, input bit er, input int n, input bit stuck);
      if (er) begin
         push_ev(EV_EN, 8'hC7, 24'h0, 1'b0, 0);
         model_polls(n, ERASE_CYC);
      end
      for (int p = 0; p < pc; p++) begin
         int          pg;
         logic [23:0] a;
         pg = (ps + p) % 8192;
         a  = 24'(pg * 1024);
         push_ev(EV_EN, 8'h84, a, 1'b1, 0);
         push_ev(EV_EN, 8'h83, a, 1'b1, GAP_CYC);
         if (stuck) begin
            model_polls(TB_TIMEOUT, GAP_CYC);
            push_ev(EV_ERR, 8'h00, 24'h0, 1'b0, 0);
            return;
         end
         model_polls(n, GAP_CYC);
      end
      push_ev(EV_DONE, 8'h00, 24'h0, 1'b0, 0);
   endtask

   //--------------------------------------------------------------------------
   // Controller / flash model
   //--------------------------------------------------------------------------
   int cyc        = 0;
   int ref_cyc    = 0;   // cycle of the last completion strobe (or C7h en)
   int rdy_after  = 1;   // RDY reported on this poll of each wait
   bit rdy_stuck  = 1'b0;
   int prog_delay = 0;   // 0 = random 83h completion delay

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      int          pend;
      int          poll_idx;
      logic [7:0]  pcmd;
      logic [31:0] d;
      pend = 0;
      poll_idx = 0;
      pcmd = 8'h00;
      wr = 1'b0;
      bufer_full = 1'b0;
      data_out = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         wr = 1'b0;
         bufer_full = 1'b0;
         if (rst) begin
            pend = 0;
            poll_idx = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  ref_cyc = cyc;
                  case (pcmd)
                     8'h84: bufer_full = 1'b1;
                     8'h83: begin
                        d = $urandom;
                        data_out = d;
                        wr = 1'b1;
                     end
                     8'hD7: begin
                        poll_idx++;
                        d = $urandom;
                        d[23] = !rdy_stuck && (poll_idx >= rdy_after);
                        data_out = d;
                        wr = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            if (en) begin
               pcmd = command;
               if (command != 8'hD7) poll_idx = 0;
               if (command == 8'hC7)
                  pend = 0;
               else if (command == 8'h83 && prog_delay > 0)
                  pend = prog_delay;
               else
                  pend = $urandom_range(5, 20);
            end
         end
      end
   end

   //--------------------------------------------------------------------------
   // Monitor / scoreboard
   //--------------------------------------------------------------------------
   int   en_count = 0;
   int   ends     = 0;

   initial begin
      ev_t  e;
      logic err_prev;
      err_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            err_prev = 1'b0;
            continue;
         end
         if (en) begin
            en_count++;
            if (exp_q.size() == 0) begin
               fail_now("unexpected_en", int'(command));
            end else begin
               e = exp_q.pop_front();
               check("ev_kind_en", EV_EN, e.kind);
               check("en_cmd", command, e.cmd);
               check("busy_at_en", busy, 1'b1);
               if (e.chk_adr) begin
                  check("en_adr", adr_data, e.adr);
                  check("page_cur", page_cur, e.adr[22:10]);
               end
               if (e.min_gap > 0)
                  check_range("en_gap", cyc - ref_cyc, e.min_gap, e.min_gap + 2);
            end
            if (command == 8'hC7) ref_cyc = cyc;
         end
         if (done) begin
            ends++;
            if (exp_q.size() == 0) begin
               fail_now("unexpected_done", cyc);
            end else begin
               e = exp_q.pop_front();
               check("ev_kind_done", EV_DONE, e.kind);
               check("busy_at_done", busy, 1'b0);
            end
         end
         if (error && !err_prev) begin
            ends++;
            if (exp_q.size() == 0) begin
               fail_now("unexpected_error", cyc);
            end else begin
               e = exp_q.pop_front();
               check("ev_kind_err", EV_ERR, e.kind);
               check("busy_at_err", busy, 1'b0);
               check("done_at_err", done, 1'b0);
            end
         end
         err_prev = error;
      end
   end

   //--------------------------------------------------------------------------
   // Stimulus helpers
   //--------------------------------------------------------------------------
   task automatic do_start(input int ps, input int pc, input bit er);
      @(posedge clk);
      #1;
      start      = 1'b1;
      page_start = 13'(ps);
      page_count = 13'(pc);
      erase_all  = er;
      @(posedge clk);
      #1;
      start      = 1'b0;
      page_start = 13'($urandom);
      page_count = 13'($urandom);
      erase_all  = 1'($urandom);
   endtask

   task automatic wait_end(input int budget, input string name);
      int e0;
      int k;
      e0 = ends;
      k  = 0;
      while (ends == e0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (ends == e0) fail_now({name, "_timeout"}, k);
      repeat (3) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_command"},  command,  8'h00);
      check({tag, "_en"},       en,       1'b0);
      check({tag, "_adr_data"}, adr_data, 24'h0);
      check({tag, "_pause"},    pause,    1'b0);
      check({tag, "_busy"},     busy,     1'b0);
      check({tag, "_done"},     done,     1'b0);
      check({tag, "_error"},    error,    1'b0);
      check({tag, "_page_cur"}, page_cur, 13'h0);
   endtask

   //--------------------------------------------------------------------------
   // Main sequence
   //--------------------------------------------------------------------------
   initial begin
      int en0;
      int k;
      int ps;
      int pc;
      int n;
      bit er;

      rst        = 1'b1;
      start      = 1'b0;
      erase_all  = 1'b0;
      page_start = '0;
      page_count = '0;
      fifo_cnt   = 11'd528;
      fifo_empty = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst        = 1'b0;
      fifo_empty = 1'b0;

      // Single page at 5, RDY on second poll: 84h, 83h, D7h, D7h, done.
      en0 = en_count;
      rdy_after = 2;
      model_job(5, 1, 1'b0, 2, 1'b0);
      do_start(5, 1, 1'b0);
      wait_end(20000, "single_page");
      check("single_page_en_count", en_count - en0, 4);
      check("single_page_busy", busy, 1'b0);
      check("single_page_queue", exp_q.size(), 0);

      // Erase only.
      rdy_after = $urandom_range(1, 2);
      model_job($urandom_range(0, 8191), 0, 1'b1, rdy_after, 1'b0);
      do_start($urandom_range(0, 8191), 0, 1'b1);
      wait_end(20000, "erase_only");
      check("erase_only_queue", exp_q.size(), 0);

      // No erase, no pages: immediate done.
      en0 = en_count;
      model_job(17, 0, 1'b0, 1, 1'b0);
      do_start(17, 0, 1'b0);
      wait_end(100, "empty_job");
      check("empty_job_no_en", en_count - en0, 0);

      // Page address wrap 8190, 8191, 0.
      rdy_after = 1;
      model_job(8190, 3, 1'b0, 1, 1'b0);
      do_start(8190, 3, 1'b0);
      wait_end(20000, "wrap");
      check("wrap_page_cur", page_cur, 13'd0);
      check("wrap_queue", exp_q.size(), 0);

      // FIFO one byte short holds the sequence; pause only in BUF_WT.
      rdy_after = 1;
      fifo_cnt  = 11'd527;
      en0 = en_count;
      model_job(200, 1, 1'b0, 1, 1'b0);
      do_start(200, 1, 1'b0);
      repeat (1000) @(posedge clk);
      check("short_fifo_no_en", en_count - en0, 0);
      #1;
      fifo_cnt   = 11'd528;
      fifo_empty = 1'b1;
      @(negedge clk);
      check("short_fifo_pause_wait", pause, 1'b0);
      @(negedge clk);
      check("fifo_ready_en", en, 1'b1);
      check("fifo_ready_pause_cmd", pause, 1'b0);
      @(negedge clk);
      check("buf_wt_pause", pause, 1'b1);
      @(posedge clk);
      #1;
      fifo_empty = 1'b0;
      @(negedge clk);
      check("buf_wt_pause_release", pause, 1'b0);
      wait_end(20000, "short_fifo");

      // Randomized jobs; one receives a start pulse while busy.
      for (int j = 0; j < 4; j++) begin
         ps = $urandom_range(0, 8191);
         pc = $urandom_range(1, 2);
         er = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 2);
         rdy_after = n;
         fifo_cnt  = 11'($urandom_range(528, 2047));
         model_job(ps, pc, er, n, 1'b0);
         do_start(ps, pc, er);
         if (j == 0) begin
            repeat (100) @(posedge clk);
            check("busy_midjob", busy, 1'b1);
            #1;
            start      = 1'b1;
            page_start = 13'($urandom);
            page_count = 13'($urandom_range(1, 8191));
            erase_all  = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         wait_end(30000, "random_job");
         check("random_job_queue", exp_q.size(), 0);
      end
      fifo_cnt = 11'd528;

`ifdef AT45_TIMEOUT_EN
      // RDY never arrives: TB_TIMEOUT polls, then error without done.
      rdy_stuck = 1'b1;
      en0 = en_count;
      model_job(300, 1, 1'b0, 1, 1'b1);
      do_start(300, 1, 1'b0);
      wait_end(30000, "timeout");
      check("timeout_en_count", en_count - en0, 2 + TB_TIMEOUT);
      check("timeout_error", error, 1'b1);
      check("timeout_busy", busy, 1'b0);
      rdy_stuck = 1'b0;
      rdy_after = 1;
      model_job(301, 1, 1'b0, 1, 1'b0);
      do_start(301, 1, 1'b0);
      check("error_cleared_by_start", error, 1'b0);
      wait_end(20000, "after_timeout");
`endif

      // Reset while waiting for 83h completion aborts everything.
      prog_delay = 60;
      rdy_after  = 1;
      model_job(100, 2, 1'b0, 1, 1'b0);
      do_start(100, 2, 1'b0);
      k = 0;
      @(negedge clk);
      while (!(en && command == 8'h83) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) fail_now("prog_en_timeout", k);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midreset");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      prog_delay = 0;
      en0 = en_count;
      repeat (500) @(posedge clk);
      check("midreset_no_en", en_count - en0, 0);
      check("midreset_busy", busy, 1'b0);

      check("final_queue", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
